// File: rtl/commutation_sequencer.sv
// Six-step BLDC commutation sequencer: hall debounce, dead-time FSM and
// registered per-phase duty/float outputs with a latched illegal-hall fault.
module commutation_sequencer #(
  parameter int DUTY_WIDTH    = 10,
  parameter int DEAD_CYCLES   = 16,
  parameter int HALL_DEBOUNCE = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  direction,
  input  logic                  brake,
  input  logic [DUTY_WIDTH-1:0] duty_in,
  input  logic [2:0]            hall,
  output logic [DUTY_WIDTH-1:0] duty_a,
  output logic [DUTY_WIDTH-1:0] duty_b,
  output logic [DUTY_WIDTH-1:0] duty_c,
  output logic                  high_z_a,
  output logic                  high_z_b,
  output logic                  high_z_c,
  output logic                  fault,
  output logic [15:0]           commutation_count
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DEAD  = 3'd1,
    DRIVE = 3'd2,
    BRAKE = 3'd3,
    FAULT = 3'd4
  } state_t;

  localparam logic [7:0] DeadLoad = 8'(DEAD_CYCLES - 1);

  function automatic logic isLegal(input logic [2:0] code);
    return (code != 3'd0) && (code != 3'd7);
  endfunction

  logic [2:0]  r_hallMeta;
  logic [2:0]  r_hallSync;
  logic [2:0]  r_hallCand;
  logic [2:0]  r_hallDeb;
  logic [4:0]  r_stableCnt;
  logic [4:0]  w_stableNext;
  logic        w_hallAccept;
  logic [15:0] r_commCount;

  // A candidate code must repeat HALL_DEBOUNCE samples in a row; any change restarts at 1.
  always_comb begin
    w_stableNext = (r_hallSync == r_hallCand) ? r_stableCnt + 5'd1 : 5'd1;
    w_hallAccept = (r_hallSync != r_hallDeb) && (w_stableNext >= 5'(HALL_DEBOUNCE));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_hallMeta  <= 3'd0;
      r_hallSync  <= 3'd0;
      r_hallCand  <= 3'd0;
      r_hallDeb   <= 3'd0;
      r_stableCnt <= 5'd0;
      r_commCount <= 16'd0;
    end else begin
      r_hallMeta <= hall;
      r_hallSync <= r_hallMeta;
      r_hallCand <= r_hallSync;
      if ((r_hallSync == r_hallDeb) || w_hallAccept) begin
        r_stableCnt <= 5'd0;
      end else begin
        r_stableCnt <= w_stableNext;
      end
      if (w_hallAccept) begin
        r_hallDeb <= r_hallSync;
        if (isLegal(r_hallDeb) && isLegal(r_hallSync)) begin
          r_commCount <= r_commCount + 16'd1;
        end
      end
    end
  end

  state_t     r_state;
  state_t     w_stateNext;
  state_t     w_followTarget;
  logic [7:0] r_deadCnt;
  logic [7:0] w_deadNext;
  logic [2:0] r_driveHall;
  logic       r_driveDir;

  // The dead-time target is simply whatever brake asks for right now, so it tracks brake for free.
  always_comb begin
    w_stateNext    = r_state;
    w_deadNext     = r_deadCnt;
    w_followTarget = brake ? BRAKE : DRIVE;
    if ((r_state != FAULT) && enable && !isLegal(r_hallDeb)) begin
      w_stateNext = FAULT;
    end else if ((r_state != FAULT) && !enable) begin
      w_stateNext = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          w_stateNext = DEAD;
          w_deadNext  = DeadLoad;
        end
        DEAD: begin
          if (r_deadCnt == 8'd0) begin
            w_stateNext = w_followTarget;
          end else begin
            w_deadNext = r_deadCnt - 8'd1;
          end
        end
        DRIVE: begin
          if (brake || (r_hallDeb != r_driveHall) || (direction != r_driveDir)) begin
            w_stateNext = DEAD;
            w_deadNext  = DeadLoad;
          end
        end
        BRAKE: begin
          if (!brake) begin
            w_stateNext = DEAD;
            w_deadNext  = DeadLoad;
          end
        end
        FAULT: begin
          if (!enable) begin
            w_stateNext = IDLE;
          end
        end
        default: w_stateNext = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= IDLE;
      r_deadCnt   <= 8'd0;
      r_driveHall <= 3'd0;
      r_driveDir  <= 1'b0;
    end else begin
      r_state   <= w_stateNext;
      r_deadCnt <= w_deadNext;
      if (r_state != DRIVE) begin
        r_driveHall <= r_hallDeb;
        r_driveDir  <= direction;
      end
    end
  end

  logic [1:0]            w_fwdHi;
  logic [1:0]            w_fwdLo;
  logic [1:0]            w_hiPhase;
  logic [1:0]            w_loPhase;
  logic                  w_tableValid;
  logic [2:0]            w_highZNext;
  logic [DUTY_WIDTH-1:0] w_dutyNext [3];

  // Phase index 0/1/2 = A/B/C; reverse rotation swaps the high and low sides.
  always_comb begin
    w_fwdHi      = 2'd0;
    w_fwdLo      = 2'd0;
    w_tableValid = 1'b1;
    case (r_driveHall)
      3'd5: begin w_fwdHi = 2'd0; w_fwdLo = 2'd1; end
      3'd4: begin w_fwdHi = 2'd0; w_fwdLo = 2'd2; end
      3'd6: begin w_fwdHi = 2'd1; w_fwdLo = 2'd2; end
      3'd2: begin w_fwdHi = 2'd1; w_fwdLo = 2'd0; end
      3'd3: begin w_fwdHi = 2'd2; w_fwdLo = 2'd0; end
      3'd1: begin w_fwdHi = 2'd2; w_fwdLo = 2'd1; end
      default: w_tableValid = 1'b0;
    endcase
    w_hiPhase = r_driveDir ? w_fwdLo : w_fwdHi;
    w_loPhase = r_driveDir ? w_fwdHi : w_fwdLo;
  end

  always_comb begin
    w_highZNext = 3'b111;
    for (int p = 0; p < 3; p++) begin
      w_dutyNext[p] = '0;
    end
    if (r_state == BRAKE) begin
      w_highZNext = 3'b000;
    end else if ((r_state == DRIVE) && w_tableValid) begin
      for (int p = 0; p < 3; p++) begin
        if ((2'(p) == w_hiPhase) || (2'(p) == w_loPhase)) begin
          w_highZNext[p] = 1'b0;
        end
        if (2'(p) == w_hiPhase) begin
          w_dutyNext[p] = duty_in;
        end
      end
    end
  end

  logic [DUTY_WIDTH-1:0] r_duty [3];
  logic [2:0]            r_highZ;
  logic                  r_fault;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int p = 0; p < 3; p++) begin
        r_duty[p] <= '0;
      end
      r_highZ <= 3'b111;
      r_fault <= 1'b0;
    end else begin
      for (int p = 0; p < 3; p++) begin
        r_duty[p] <= w_dutyNext[p];
      end
      r_highZ <= w_highZNext;
      r_fault <= (r_state == FAULT);
    end
  end

  assign duty_a            = r_duty[0];
  assign duty_b            = r_duty[1];
  assign duty_c            = r_duty[2];
  assign high_z_a          = r_highZ[0];
  assign high_z_b          = r_highZ[1];
  assign high_z_c          = r_highZ[2];
  assign fault             = r_fault;
  assign commutation_count = r_commCount;

endmodule
